// File: rtl/regfile_rd.sv
// 32 x DATA_W register file with registered dual read port, stall and X31 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-edge write data to an accepted read.
module regfile_rd #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [4:0]        rd_addr_a,
  input  logic [4:0]        rd_addr_b,
  input  logic              stall,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  localparam logic [4:0] ZERO_IDX = 5'd31;

  logic [DATA_W-1:0] regs [0:30];
  logic              wr_hit;
  logic              rd_accept;
  logic [DATA_W-1:0] nxt_a;
  logic [DATA_W-1:0] nxt_b;

  assign wr_hit    = wr_en && (wr_addr != ZERO_IDX);
  assign rd_accept = rd_req && !stall;

  function automatic logic [DATA_W-1:0] port_val(
    input logic [4:0]        addr,
    input logic              hit,
    input logic [4:0]        waddr,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] v;
    v = stored;
`ifdef REGFILE_BYPASS_EN
    if (hit && (waddr == addr)) v = wdata;
`else
    if (hit && (waddr == addr) && 1'b0) v = wdata;
`endif
    if (addr == ZERO_IDX) v = '0;
    return v;
  endfunction

  // The read mux never indexes entry 31; it is forced to zero by port_val.
  always_comb begin
    nxt_a = port_val(rd_addr_a, wr_hit, wr_addr, wr_data,
                     (rd_addr_a == ZERO_IDX) ? '0 : regs[rd_addr_a]);
    nxt_b = port_val(rd_addr_b, wr_hit, wr_addr, wr_data,
                     (rd_addr_b == ZERO_IDX) ? '0 : regs[rd_addr_b]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 31; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid  <= 1'b0;
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else if (!stall) begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_data_a <= nxt_a;
        rd_data_b <= nxt_b;
      end
    end
  end

endmodule

// File: doc/regfile_rd.md
REGFILE_RD -- requirements
Module: regfile_rd

Interface
REQ-001 Parameter: DATA_W, default 64, register and data-port width in bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 wr_en  input  1  write strobe from the writeback side.
REQ-005 wr_addr  input  5  destination register index, 0..31.
REQ-006 wr_data  input  DATA_W  write data.
REQ-007 rd_req  input  1  read request; sampled on the rising clk edge.
REQ-008 rd_addr_a  input  5  read port A index.
REQ-009 rd_addr_b  input  5  read port B index.
REQ-010 stall  input  1  holds the read output stage and blocks acceptance of rd_req.
REQ-011 rd_valid  output  1  rd_data_a and rd_data_b hold the result of an accepted request.
REQ-012 rd_data_a  output  DATA_W  registered read data, port A.
REQ-013 rd_data_b  output  DATA_W  registered read data, port B.

Function
REQ-014 The block SHALL contain 32 DATA_W-bit registers, X0..X31; X31 is hardwired zero.
REQ-015 Write: on a rising clk edge with wr_en=1 and wr_addr!=31, register[wr_addr] SHALL load wr_data.
REQ-016 Write: wr_en=0 or wr_addr=31 SHALL leave all registers unchanged.
REQ-017 Write: a write SHALL be unaffected by stall and rd_req.
REQ-018 Read accept: a request is accepted on a rising edge with rd_req=1 and stall=0.
REQ-019 Read latency: after an accepted request, rd_data_a/b SHALL hold register[rd_addr_a]/[rd_addr_b] and rd_valid SHALL be 1 from the following cycle (1-cycle latency).
REQ-020 Read address 31 SHALL return all zeros on either port.
REQ-021 Idle: on a rising edge with rd_req=0 and stall=0, rd_valid SHALL go to 0 and rd_data_a/b SHALL hold their previous values.
REQ-022 Stall: on a rising edge with stall=1, rd_valid, rd_data_a and rd_data_b SHALL hold regardless of rd_req. The request is not accepted and is re-presented by the requester.
REQ-023 Back-to-back: accepted requests on consecutive edges SHALL produce consecutive valid results with no bubble.
REQ-024 Same-register read/write: if an accepted read and a write target the same index (!=31) on the same edge, the returned value SHALL follow REQ-032/REQ-033.
REQ-025 Both ports SHALL be independent; rd_addr_a = rd_addr_b SHALL return identical data on both ports.

Reset
REQ-026 Assertion of reset (low) SHALL immediately, without waiting for clk, clear all 32 registers to 0.
REQ-027 Assertion of reset SHALL also clear rd_data_a and rd_data_b to 0 and rd_valid to 0.
REQ-028 While reset is low, writes and read requests SHALL be ignored.
REQ-029 A reset mid-request SHALL discard the pending result; rd_valid SHALL stay 0 until a request is accepted after deassertion.
REQ-030 The first rising edge after reset deasserts SHALL operate normally.

Configuration
REQ-031 The macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-032 With REGFILE_BYPASS_EN defined: on a same-edge write and accepted read to the same index (!=31), the port SHALL return wr_data.
REQ-033 Without REGFILE_BYPASS_EN: the port SHALL return the register's pre-write value, and the new value is visible from the next accepted read.
REQ-034 Forwarding SHALL never apply to index 31.

Verification
REQ-035 Write X5=0x1234, then read A=5, B=31 -> next cycle rd_valid=1, A=0x1234, B=0.
REQ-036 Write X31=0xFFFF then read 31 -> data 0. Write with wr_en=0 -> register unchanged.
REQ-037 X7=0xAA, then same edge: write X7=0xBB and read 7 -> returns 0xBB with REGFILE_BYPASS_EN defined, 0xAA without it. The next read returns 0xBB in both builds.
REQ-038 Valid result A=0x1234, then stall=1 for 3 cycles with rd_req=1 and new addresses -> outputs hold 0x1234 and rd_valid=1. Release stall -> new data on the next cycle.
REQ-039 Consecutive requests to X1, X2, X3 (values 1, 2, 3) -> rd_data_a 1, 2, 3 on consecutive cycles. rd_req=0 afterward -> rd_valid=0 and data holds 3.
REQ-040 Load X1..X30, assert reset between clk edges -> outputs and rd_valid 0 immediately. After release, reads of all indices return 0.
